evt_buf_frmt: RTL and testbench
===============================

EVT_BUF_FRMT -- requirements
Module: evt_buf_frmt

Interface
REQ-001 SHALL have parameter NCHAN, default 16: data words per sample (event words = SAMP_MAX*NCHAN).
REQ-002 SHALL have parameter DATA_AW, default 11: data FIFO depth 2**DATA_AW words of 18 bits.
REQ-003 SHALL have parameter HDR_AW, default 4: header FIFO depth 2**HDR_AW entries of 37 bits.
REQ-004 SHALL have parameter AFL_MARGIN, default 64: free data words at or below which almost-full asserts.
REQ-005 SHALL have these ports:
  CLK  in  1  clock;
  RST_RESYNC  in  1  reset, asynchronous, active-high;
  FIFO_RST  in  1  synchronous clear of both FIFOs and OVFL;
  SAMP_MAX  in  7  samples per event;
  L1A_EVT_DATA  in  37  {l1a_phs, l1a_mtch_num[11:0], l1anum[23:0]};
  L1A_EVT_PUSH  in  1  header write strobe;
  RDATA  in  18  {movlp, ovrlp, ocnt[3:0], adc[11:0]};
  DATA_PUSH  in  1  data write strobe;
  EVT_BUF_AMT  out  1  both FIFOs empty;
  EVT_BUF_AFL  out  1  almost full;
  RD_EN  in  1  downstream ready;
  DOUT  out  18  frame word;
  DOUT_VLD  out  1  DOUT valid;
  DOUT_LAST  out  1  trailer word marker;
  OVFL  out  1  sticky overflow.

Function
REQ-006 SHALL write L1A_EVT_DATA into the header FIFO on L1A_EVT_PUSH, and RDATA into the data FIFO on DATA_PUSH, one entry per strobe cycle.
REQ-007 SHALL drop a push arriving when its FIFO is full (full as of the start of that cycle, even with a same-cycle pop) and set OVFL; OVFL holds until FIFO_RST or reset.
REQ-008 SHALL keep occupancy unchanged on a simultaneous push and pop.
REQ-009 SHALL drive EVT_BUF_AMT registered, equal to 1 when both occupancies are 0.
REQ-010 SHALL drive EVT_BUF_AFL registered, equal to 1 when data free words <= AFL_MARGIN or header occupancy >= 2**HDR_AW-2.
REQ-011 SHALL use FSM states IDLE, HDR0, HDR1, HDR2, DATA, TRL.
REQ-012 SHALL leave IDLE for HDR0 when the header FIFO is non-empty and data occupancy >= SAMP_MAX*NCHAN, and SHALL latch evt_words = SAMP_MAX*NCHAN (12 bits) on that transition.
REQ-013 SHALL make the first frame word visible in the cycle after the IDLE start condition is true.
REQ-014 SHALL emit the frame words in this order:
  HDR0 = {6'h2A, l1anum[11:0]};
  HDR1 = {6'h2B, l1anum[23:12]};
  HDR2 = {5'h1C, l1a_phs, l1a_mtch_num};
  DATA = evt_words raw RDATA words;
  TRL = {6'h3E, word count}, where word count = evt_words + 4.
REQ-015 SHALL transfer a word only when DOUT_VLD=1 and RD_EN=1, and SHALL hold DOUT stable while DOUT_VLD=1 and RD_EN=0.
REQ-016 SHALL sustain one word per cycle while RD_EN stays high, with no bubbles between states.
REQ-017 SHALL pop the header FIFO on TRL transfer and the data FIFO on each DATA transfer.
REQ-018 SHALL go from HDR2 directly to TRL when evt_words = 0.
REQ-019 SHALL assert DOUT_LAST only with the TRL word; after the TRL transfer the FSM returns to IDLE, or to HDR0 if the start condition already holds for the next event.
REQ-020 SHALL make SAMP_MAX changes take effect only at the next IDLE->HDR0 transition.
REQ-021 SHALL, on FIFO_RST, empty both FIFOs, clear OVFL, force IDLE and deassert DOUT_VLD in the next cycle, dropping any partial frame.

Reset
REQ-022 SHALL, while RST_RESYNC=1, hold FSM=IDLE, occupancies=0, DOUT=0, DOUT_VLD=0, DOUT_LAST=0, OVFL=0, EVT_BUF_AMT=1, EVT_BUF_AFL=0.
REQ-023 SHALL abandon an in-progress frame on reset mid-frame; no trailer is emitted.

Structure
REQ-024 SHALL place in a shared package: the frame marker constants (2A, 2B, 1C, 3E), the FSM state encoding, and the header field widths.
REQ-025 SHALL implement both queues as two instances of one sub-module, evt_fifo: synchronous first-word-fall-through FIFO, parameterised width and depth, with full, empty and occupancy outputs.

Verification
REQ-026 SAMP_MAX=8, NCHAN=16, one header (l1anum=24'h123456, mtch=12'h0AB, phs=1), then 128 data pushes, RD_EN=1 -> words 2A456, 2B123, 1C0AB with phs bit set, 128 data words unchanged, trailer 3E084 with DOUT_LAST; 132 consecutive cycles.
REQ-027 Same event, RD_EN toggled 1/0 every cycle -> identical sequence; DOUT unchanged in every stalled cycle.
REQ-028 Header pushed, only 127 data words pushed -> DOUT_VLD stays 0; 128th push -> frame starts on the next cycle.
REQ-029 Fill the data FIFO to 2048, then one extra DATA_PUSH -> push dropped, OVFL=1, EVT_BUF_AFL=1; FIFO_RST -> OVFL=0, EVT_BUF_AMT=1.
REQ-030 SAMP_MAX=0 with one header -> exactly 4 words: three header words, then 3E004 with DOUT_LAST.
REQ-031 RST_RESYNC pulsed during DATA of event 1, then event 2 pushed -> a complete frame for event 2 only, with no stale event 1 words.

Source files
------------

// File: rtl/evt_buf_frmt_pkg.sv
// evt_buf_frmt_pkg: frame markers, FSM states and header field layout for the event buffer
package evt_buf_frmt_pkg;
  localparam int PHS_W = 1;
  localparam int MTCH_W = 12;
  localparam int L1A_W = 24;
  localparam int HDR_W = PHS_W + MTCH_W + L1A_W;
  localparam int WORD_W = 18;
  localparam logic [5:0] MRK_HDR0 = 6'h2A;
  localparam logic [5:0] MRK_HDR1 = 6'h2B;
  localparam logic [4:0] MRK_HDR2 = 5'h1C;
  localparam logic [5:0] MRK_TRL = 6'h3E;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA, TRL} state_t;
  typedef struct packed {
    logic [PHS_W-1:0] phs;
    logic [MTCH_W-1:0] mtch;
    logic [L1A_W-1:0] l1anum;
  } hdr_t;
endpackage

// File: rtl/evt_buf_frmt_fifo.sv
// evt_fifo: first-word-fall-through FIFO; pushes while full are dropped, occupancy exposed
module evt_fifo #(
  parameter int W = 18,
  parameter int AW = 11
) (
  input  logic          CLK,
  input  logic          RST_RESYNC,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   cnt
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = cnt[AW];
  assign empty = cnt == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge CLK)
    if (wr) mem[wp] <= din;
  always_ff @(posedge CLK or posedge RST_RESYNC)
    if (RST_RESYNC) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/evt_buf_frmt.sv
// evt_buf_frmt: buffers event headers and sample data, emits framed header/data/trailer words
module evt_buf_frmt
  import evt_buf_frmt_pkg::*;
#(
  parameter int NCHAN = 16,
  parameter int DATA_AW = 11,
  parameter int HDR_AW = 4,
  parameter int AFL_MARGIN = 64
) (
  input  logic                 CLK,
  input  logic                 RST_RESYNC,
  input  logic                 FIFO_RST,
  input  logic [6:0]           SAMP_MAX,
  input  logic [HDR_W-1:0]     L1A_EVT_DATA,
  input  logic                 L1A_EVT_PUSH,
  input  logic [WORD_W-1:0]    RDATA,
  input  logic                 DATA_PUSH,
  output logic                 EVT_BUF_AMT,
  output logic                 EVT_BUF_AFL,
  input  logic                 RD_EN,
  output logic [WORD_W-1:0]    DOUT,
  output logic                 DOUT_VLD,
  output logic                 DOUT_LAST,
  output logic                 OVFL
);
  state_t st, nxt;
  hdr_t hd;
  logic [HDR_W-1:0] h_dout;
  logic [WORD_W-1:0] d_dout;
  logic [HDR_AW:0] h_cnt;
  logic [DATA_AW:0] d_cnt;
  logic h_full, h_empty, d_full, d_empty, h_pop, d_pop;
  logic data_ok, start, again, ld;
  logic [11:0] need, evt_words, dcnt;

  evt_fifo #(.W(HDR_W), .AW(HDR_AW)) u_hdr (
    .CLK, .RST_RESYNC, .clr(FIFO_RST), .push(L1A_EVT_PUSH), .pop(h_pop),
    .din(L1A_EVT_DATA), .dout(h_dout), .full(h_full), .empty(h_empty), .cnt(h_cnt)
  );
  evt_fifo #(.W(WORD_W), .AW(DATA_AW)) u_data (
    .CLK, .RST_RESYNC, .clr(FIFO_RST), .push(DATA_PUSH), .pop(d_pop),
    .din(RDATA), .dout(d_dout), .full(d_full), .empty(d_empty), .cnt(d_cnt)
  );

  assign hd = h_dout;
  assign need = 12'(SAMP_MAX) * 12'(NCHAN);
  assign data_ok = int'(d_cnt) >= int'(need);
  assign start = !h_empty && data_ok;
  assign again = h_cnt > (HDR_AW+1)'(1) && data_ok;
  assign h_pop = st == TRL && RD_EN;
  assign d_pop = st == DATA && RD_EN;

  always_ff @(posedge CLK or posedge RST_RESYNC)
    if (RST_RESYNC) st <= IDLE;
    else st <= FIFO_RST ? IDLE : nxt;

  always_comb begin
    nxt = st;
    ld = 1'b0;
    case (st)
      IDLE: begin
        nxt = start ? HDR0 : IDLE;
        ld = start;
      end
      HDR0: nxt = RD_EN ? HDR1 : HDR0;
      HDR1: nxt = RD_EN ? HDR2 : HDR1;
      HDR2: nxt = !RD_EN ? HDR2 : evt_words == '0 ? TRL : DATA;
      DATA: nxt = RD_EN && dcnt == evt_words - 12'd1 ? TRL : DATA;
      TRL: begin
        nxt = !RD_EN ? TRL : again ? HDR0 : IDLE;
        ld = RD_EN && again;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_RESYNC)
    if (RST_RESYNC) begin
      evt_words <= '0;
      dcnt <= '0;
    end else if (ld) begin
      evt_words <= need;
      dcnt <= '0;
    end else if (d_pop) begin
      dcnt <= dcnt + 12'd1;
    end

  always_ff @(posedge CLK or posedge RST_RESYNC)
    if (RST_RESYNC) begin
      OVFL <= 1'b0;
      EVT_BUF_AMT <= 1'b1;
      EVT_BUF_AFL <= 1'b0;
    end else begin
      OVFL <= !FIFO_RST && (OVFL || (L1A_EVT_PUSH && h_full) || (DATA_PUSH && d_full));
      EVT_BUF_AMT <= h_empty && d_empty;
      EVT_BUF_AFL <= (2**DATA_AW - int'(d_cnt) <= AFL_MARGIN) || (int'(h_cnt) >= 2**HDR_AW - 2);
    end

  always_comb
    DOUT = st == HDR0 ? {MRK_HDR0, hd.l1anum[11:0]}
         : st == HDR1 ? {MRK_HDR1, hd.l1anum[23:12]}
         : st == HDR2 ? {MRK_HDR2, hd.phs, hd.mtch}
         : st == DATA ? d_dout
         : st == TRL  ? {MRK_TRL, evt_words + 12'd4}
         : '0;
  assign DOUT_VLD = st != IDLE;
  assign DOUT_LAST = st == TRL;
endmodule

// File: tb/tb_evt_buf_frmt.sv
// tb_evt_buf_frmt: directed frame, stall, threshold, overflow and reset checks for evt_buf_frmt
module tb_evt_buf_frmt;
  logic CLK, RST_RESYNC, FIFO_RST, L1A_EVT_PUSH, DATA_PUSH, RD_EN;
  logic [6:0] SAMP_MAX;
  logic [36:0] L1A_EVT_DATA;
  logic [17:0] RDATA, DOUT;
  logic EVT_BUF_AMT, EVT_BUF_AFL, DOUT_VLD, DOUT_LAST, OVFL;
  logic [18:0] exp_q[$];
  int n_chk = 0, n_err = 0;

  evt_buf_frmt dut (
    .CLK(CLK), .RST_RESYNC(RST_RESYNC), .FIFO_RST(FIFO_RST), .SAMP_MAX(SAMP_MAX),
    .L1A_EVT_DATA(L1A_EVT_DATA), .L1A_EVT_PUSH(L1A_EVT_PUSH), .RDATA(RDATA),
    .DATA_PUSH(DATA_PUSH), .EVT_BUF_AMT(EVT_BUF_AMT), .EVT_BUF_AFL(EVT_BUF_AFL),
    .RD_EN(RD_EN), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_LAST(DOUT_LAST), .OVFL(OVFL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [17:0] dw(input int base, input int i);
    return 18'(base * 4099 + i * 37 + 11);
  endfunction

  task automatic push_hdr(input logic [23:0] l1a, input logic [11:0] mtch, input logic phs);
    L1A_EVT_DATA = {phs, mtch, l1a};
    L1A_EVT_PUSH = 1'b1;
    tick;
    L1A_EVT_PUSH = 1'b0;
  endtask

  task automatic push_data(input int n, input int base, input int first);
    for (int i = first; i < first + n; i++) begin
      RDATA = dw(base, i);
      DATA_PUSH = 1'b1;
      tick;
    end
    DATA_PUSH = 1'b0;
  endtask

  task automatic add_frame(input logic [23:0] l1a, input logic [11:0] mtch, input logic phs,
                           input int nd, input int base, input int first);
    exp_q.push_back({1'b0, 6'h2A, l1a[11:0]});
    exp_q.push_back({1'b0, 6'h2B, l1a[23:12]});
    exp_q.push_back({1'b0, 5'h1C, phs, mtch});
    for (int i = first; i < first + nd; i++) exp_q.push_back({1'b0, dw(base, i)});
    exp_q.push_back({1'b1, 6'h3E, 12'(nd + 4)});
  endtask

  task automatic rx(input bit tog, input int budget);
    int idx = 0, cyc = 0, bub = 0, n = exp_q.size();
    bit held_v = 1'b0;
    logic [17:0] held = '0;
    while (idx < n && cyc < budget) begin
      RD_EN = tog ? (cyc % 2 == 0) : 1'b1;
      if (held_v) chk("hold", DOUT, held);
      held_v = 1'b0;
      if (DOUT_VLD && RD_EN) begin
        chk($sformatf("word%0d", idx), {DOUT_LAST, DOUT}, exp_q[idx]);
        idx++;
      end else if (DOUT_VLD) begin
        held_v = 1'b1;
        held = DOUT;
      end else if (idx > 0 && RD_EN) bub++;
      tick;
      cyc++;
    end
    chk("complete", idx, n);
    chk("bubbles", bub, 0);
    exp_q.delete();
  endtask

  initial begin
    RST_RESYNC = 1'b1;
    FIFO_RST = 1'b0;
    SAMP_MAX = 7'd8;
    L1A_EVT_DATA = '0;
    L1A_EVT_PUSH = 1'b0;
    RDATA = '0;
    DATA_PUSH = 1'b0;
    RD_EN = 1'b0;
    repeat (3) tick;
    chk("rst_vld", DOUT_VLD, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_last", DOUT_LAST, 0);
    chk("rst_ovfl", OVFL, 0);
    chk("rst_amt", EVT_BUF_AMT, 1);
    chk("rst_afl", EVT_BUF_AFL, 0);
    RST_RESYNC = 1'b0;
    tick;

    // single event, continuous read
    push_hdr(24'h123456, 12'h0AB, 1'b1);
    push_data(128, 1, 0);
    exp_q.push_back({1'b0, 18'h2A456});
    exp_q.push_back({1'b0, 18'h2B123});
    exp_q.push_back({1'b0, 18'h390AB});
    for (int i = 0; i < 128; i++) exp_q.push_back({1'b0, dw(1, i)});
    exp_q.push_back({1'b1, 18'h3E084});
    rx(1'b0, 1000);
    chk("idle_after", DOUT_VLD, 0);
    tick;
    chk("amt_after", EVT_BUF_AMT, 1);

    // same event, read enable toggling
    RD_EN = 1'b0;
    push_hdr(24'h123456, 12'h0AB, 1'b1);
    push_data(128, 1, 0);
    exp_q.push_back({1'b0, 18'h2A456});
    exp_q.push_back({1'b0, 18'h2B123});
    exp_q.push_back({1'b0, 18'h390AB});
    for (int i = 0; i < 128; i++) exp_q.push_back({1'b0, dw(1, i)});
    exp_q.push_back({1'b1, 18'h3E084});
    rx(1'b1, 1000);
    chk("idle_after_tog", DOUT_VLD, 0);

    // start threshold, SAMP_MAX change mid-frame ignored
    RD_EN = 1'b0;
    push_hdr(24'h0F00D1, 12'h321, 1'b0);
    push_data(127, 2, 0);
    repeat (3) begin
      chk("no_start", DOUT_VLD, 0);
      tick;
    end
    push_data(1, 2, 127);
    chk("pre_start", DOUT_VLD, 0);
    tick;
    chk("start", DOUT_VLD, 1);
    SAMP_MAX = 7'd2;
    add_frame(24'h0F00D1, 12'h321, 1'b0, 128, 2, 0);
    rx(1'b0, 1000);
    chk("idle_after_thr", DOUT_VLD, 0);

    // SAMP_MAX=0: header-only frame
    RD_EN = 1'b0;
    SAMP_MAX = 7'd0;
    push_hdr(24'hABCDEF, 12'h123, 1'b0);
    exp_q.push_back({1'b0, 18'h2ADEF});
    exp_q.push_back({1'b0, 18'h2BABC});
    exp_q.push_back({1'b0, 18'h38123});
    exp_q.push_back({1'b1, 18'h3E004});
    rx(1'b0, 100);
    chk("idle_after_zero", DOUT_VLD, 0);

    // two queued events run back to back
    RD_EN = 1'b0;
    SAMP_MAX = 7'd2;
    push_hdr(24'h000111, 12'h001, 1'b1);
    push_hdr(24'h000222, 12'h002, 1'b0);
    push_data(64, 3, 0);
    add_frame(24'h000111, 12'h001, 1'b1, 32, 3, 0);
    add_frame(24'h000222, 12'h002, 1'b0, 32, 3, 32);
    rx(1'b0, 500);
    chk("idle_after_b2b", DOUT_VLD, 0);

    // almost-full boundary, overflow, FIFO_RST
    RD_EN = 1'b0;
    SAMP_MAX = 7'd8;
    push_data(1983, 4, 0);
    tick;
    chk("afl_free65", EVT_BUF_AFL, 0);
    push_data(1, 4, 1983);
    tick;
    chk("afl_free64", EVT_BUF_AFL, 1);
    push_data(64, 4, 1984);
    chk("ovfl_full", OVFL, 0);
    push_data(1, 4, 2048);
    chk("ovfl_set", OVFL, 1);
    tick;
    chk("ovfl_sticky", OVFL, 1);
    chk("afl_full", EVT_BUF_AFL, 1);
    chk("vld_nohdr", DOUT_VLD, 0);
    FIFO_RST = 1'b1;
    tick;
    FIFO_RST = 1'b0;
    chk("ovfl_clr", OVFL, 0);
    tick;
    chk("amt_clr", EVT_BUF_AMT, 1);
    chk("afl_clr", EVT_BUF_AFL, 0);

    // reset mid-frame, then a fresh event
    push_hdr(24'h555555, 12'h055, 1'b0);
    push_data(128, 5, 0);
    RD_EN = 1'b1;
    repeat (8) tick;
    chk("mid_vld", DOUT_VLD, 1);
    chk("mid_dout", DOUT, dw(5, 4));
    RST_RESYNC = 1'b1;
    #1;
    chk("rst_mid_vld", DOUT_VLD, 0);
    chk("rst_mid_dout", DOUT, 0);
    tick;
    RST_RESYNC = 1'b0;
    tick;
    chk("rst_mid_amt", EVT_BUF_AMT, 1);
    chk("rst_mid_idle", DOUT_VLD, 0);
    RD_EN = 1'b0;
    SAMP_MAX = 7'd1;
    push_hdr(24'h777777, 12'h077, 1'b1);
    push_data(16, 6, 0);
    add_frame(24'h777777, 12'h077, 1'b1, 16, 6, 0);
    rx(1'b0, 200);
    chk("idle_after_rst", DOUT_VLD, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
